neuron_state_sram: RTL and testbench

- Parametrised single-clock state memory for neuron state words, e.g. membrane potentials.
- One registered read port and one write port. Each write is either an overwrite or a saturating signed accumulate (read-modify-write).
- Back-to-back accumulates to the same address are forwarded, so no update is lost.
- Replaces whole-array asynchronous reset with a sequenced clear engine that walks every address. This runs after reset and on request.

---
 rtl/neuron_sram_pkg.sv | 17 +
 rtl/sram_sat_add.sv | 28 ++
 rtl/neuron_state_sram.sv | 146 ++++++++++++++
 tb/tb_neuron_state_sram.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_sram_pkg.sv
// Shared types and saturation-limit helpers for the neuron state memory.
package neuron_sram_pkg;

  typedef enum logic {WR_OVERWRITE = 1'b0, WR_ACCUM = 1'b1} wr_mode_e;

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} clr_state_e;

  // Limits are returned 64 bits wide; callers truncate to their word width.
  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/sram_sat_add.sv
// Combinational signed adder that clamps to the representable WIDTH-bit range.
module sram_sat_add
  import neuron_sram_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    sat
);

  logic signed [WIDTH:0] wide;

  always_comb begin
    wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Overflow shows up as the two top bits of the extended sum disagreeing.
    sat  = wide[WIDTH] != wide[WIDTH-1];
    if (!sat) begin
      sum = wide[WIDTH-1:0];
    end else if (wide[WIDTH]) begin
      sum = WIDTH'(sat_min(WIDTH));
    end else begin
      sum = WIDTH'(sat_max(WIDTH));
    end
  end

endmodule

// File: rtl/neuron_state_sram.sv
// Neuron state memory: registered read, overwrite/saturating-accumulate write
// pipeline with forwarding, and a sequenced clear engine in place of array reset.
module neuron_state_sram
  import neuron_sram_pkg::*;
#(
  parameter int unsigned             WIDTH       = 32,
  parameter int unsigned             DEPTH       = 256,
  parameter logic signed [WIDTH-1:0] CLEAR_VALUE = '0,
  parameter int unsigned             AW          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_start,
  output logic                    busy,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic                    wr_mode,
  input  logic signed [WIDTH-1:0] wr_data,
  output logic                    sat_event
);

  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic signed [WIDTH-1:0] mem [DEPTH];

  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic                    s1_valid_q;
  logic [AW-1:0]           s1_addr_q;
  logic signed [WIDTH-1:0] s1_data_q;
  logic signed [WIDTH-1:0] s1_old_q;
  wr_mode_e                s1_mode_q;

  logic signed [WIDTH-1:0] sat_sum;
  logic                    sat_hit;
  logic signed [WIDTH-1:0] commit_data;
  logic signed [WIDTH-1:0] old_d;
  logic signed [WIDTH-1:0] rd_next;
  logic                    wr_in_range, rd_in_range;
  logic                    wr_ok, rd_ok;

  // Clear engine FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = (state_q == ST_CLEAR);
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  sram_sat_add #(
    .WIDTH(WIDTH)
  ) u_sat_add (
    .a  (s1_old_q),
    .b  (s1_data_q),
    .sum(sat_sum),
    .sat(sat_hit)
  );

  always_comb begin
    wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
    wr_ok       = wr_en && !busy && wr_in_range;
    rd_ok       = rd_en && !busy;
    commit_data = (s1_mode_q == WR_ACCUM) ? sat_sum : s1_data_q;
    // Forward the in-flight commit so back-to-back accumulates see each other.
    if (s1_valid_q && (s1_addr_q == wr_addr)) begin
      old_d = commit_data;
    end else begin
      old_d = mem[wr_addr];
    end
    if (!rd_in_range) begin
      rd_next = CLEAR_VALUE;
    end else if (s1_valid_q && (s1_addr_q == rd_addr)) begin
      rd_next = commit_data;
    end else begin
      rd_next = mem[rd_addr];
    end
  end

  // A clear write wins over a same-edge commit; the walk rewrites every word anyway.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt_q] <= CLEAR_VALUE;
    end else if (s1_valid_q) begin
      mem[s1_addr_q] <= commit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      s1_addr_q <= wr_addr;
      s1_data_q <= wr_data;
      s1_mode_q <= wr_mode_e'(wr_mode);
      s1_old_q  <= old_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      sat_event  <= 1'b0;
    end else begin
      s1_valid_q <= wr_ok;
      rd_valid   <= rd_ok;
      sat_event  <= s1_valid_q && (s1_mode_q == WR_ACCUM) && sat_hit;
      if (rd_ok) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_neuron_state_sram.sv
// Directed self-checking bench for neuron_state_sram at WIDTH=8, DEPTH=16.
module tb_neuron_state_sram;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    clear_start = 1'b0;
  logic                    busy;
  logic                    rd_en = 1'b0;
  logic [AW-1:0]           rd_addr = '0;
  logic signed [WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic                    wr_en = 1'b0;
  logic [AW-1:0]           wr_addr = '0;
  logic                    wr_mode = 1'b0;
  logic signed [WIDTH-1:0] wr_data = '0;
  logic                    sat_event;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  neuron_state_sram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .CLEAR_VALUE(8'sd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear_start(clear_start),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_mode    (wr_mode),
    .wr_data    (wr_data),
    .sat_event  (sat_event)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic signed [WIDTH-1:0] d,
                           output logic v);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    d     = rd_data;
    v     = rd_valid;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic signed [WIDTH-1:0] d,
                            input logic mode);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mode = mode;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic signed [WIDTH-1:0] d;
    logic v;
    int cnt;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'sd0 || sat_event !== 1'b0)
      $display("FAIL reset_values busy=%b rd_valid=%b rd_data=%0d sat=%b want 1 0 0 0",
               busy, rd_valid, rd_data, sat_event);
    else n_pass++;
    reset = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
      n_checks++;
      if (rd_valid !== 1'b0 || sat_event !== 1'b0)
        $display("FAIL init_quiet rd_valid=%b sat=%b want 0 0", rd_valid, sat_event);
      else n_pass++;
    end
    n_checks++;
    if (cnt != 16) $display("FAIL init_busy_cycles got %0d want 16", cnt);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      read_word(AW'(i), d, v);
      n_checks++;
      if (d !== 8'sd0 || v !== 1'b1)
        $display("FAIL init_read addr=%0d data=%0d valid=%b want 0 1", i, d, v);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL rd_valid_idle got %b want 0", rd_valid);
    else n_pass++;
  endtask

  task automatic test_overwrite();
    logic signed [WIDTH-1:0] d;
    logic v;
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    write_word(4'd3, -8'sd5, 1'b0);
    rd_en = 1'b0;
    n_checks++;
    if (rd_data !== 8'sd0 || rd_valid !== 1'b1)
      $display("FAIL same_cycle_read data=%0d valid=%b want 0 1", rd_data, rd_valid);
    else n_pass++;
    tick();
    read_word(4'd3, d, v);
    n_checks++;
    if (d !== -8'sd5 || v !== 1'b1)
      $display("FAIL overwrite_read data=%0d valid=%b want -5 1", d, v);
    else n_pass++;
    tick();
    n_checks++;
    if (rd_data !== -8'sd5 || rd_valid !== 1'b0)
      $display("FAIL rd_data_hold data=%0d valid=%b want -5 0", rd_data, rd_valid);
    else n_pass++;
  endtask

  task automatic test_accum_forward();
    logic signed [WIDTH-1:0] d;
    logic v;
    write_word(4'd5, 8'sd10, 1'b1);
    write_word(4'd5, 8'sd20, 1'b1);
    write_word(4'd5, 8'sd30, 1'b1);
    // Third accumulate commits on this edge; the read must bypass it.
    read_word(4'd5, d, v);
    n_checks++;
    if (d !== 8'sd60) $display("FAIL accum_bypass_read got %0d want 60", d);
    else n_pass++;
    tick();
    read_word(4'd5, d, v);
    n_checks++;
    if (d !== 8'sd60 || v !== 1'b1)
      $display("FAIL accum_forward got %0d valid=%b want 60 1", d, v);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [AW-1:0]           addr_v [3] = '{4'd7, 4'd8, 4'd9};
    logic signed [WIDTH-1:0] init_v [3] = '{8'sd120, -8'sd120, 8'sd100};
    logic signed [WIDTH-1:0] add_v  [3] = '{8'sd10, -8'sd10, 8'sd20};
    logic signed [WIDTH-1:0] exp_v  [3] = '{8'sd127, -8'sd128, 8'sd120};
    logic                    sat_v  [3] = '{1'b1, 1'b1, 1'b0};
    logic signed [WIDTH-1:0] d;
    logic v;
    for (int i = 0; i < 3; i++) begin
      write_word(addr_v[i], init_v[i], 1'b0);
      write_word(addr_v[i], add_v[i], 1'b1);
      n_checks++;
      if (sat_event !== 1'b0) $display("FAIL sat_early case=%0d got %b want 0", i, sat_event);
      else n_pass++;
      tick();
      n_checks++;
      if (sat_event !== sat_v[i])
        $display("FAIL sat_event case=%0d got %b want %b", i, sat_event, sat_v[i]);
      else n_pass++;
      tick();
      n_checks++;
      if (sat_event !== 1'b0) $display("FAIL sat_pulse_len case=%0d got %b want 0", i, sat_event);
      else n_pass++;
      read_word(addr_v[i], d, v);
      n_checks++;
      if (d !== exp_v[i]) $display("FAIL sat_value case=%0d got %0d want %0d", i, d, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_during_busy();
    logic signed [WIDTH-1:0] d;
    logic v;
    int cnt;
    write_word(4'd2, 8'sd9, 1'b0);
    tick();
    read_word(4'd2, d, v);
    n_checks++;
    if (d !== 8'sd9) $display("FAIL pre_clear_read got %0d want 9", d);
    else n_pass++;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL clear_busy_rise got %b want 1", busy);
    else n_pass++;
    cnt = 0;
    while (busy && cnt < 100) begin
      wr_en       = 1'b1;
      wr_addr     = 4'd4;
      wr_data     = 8'sd7;
      wr_mode     = 1'b0;
      rd_en       = 1'b1;
      rd_addr     = 4'd2;
      clear_start = (cnt == 3);
      tick();
      cnt++;
      n_checks++;
      if (rd_valid !== 1'b0) $display("FAIL busy_rd_valid cycle=%0d got %b want 0", cnt, rd_valid);
      else n_pass++;
    end
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    clear_start = 1'b0;
    n_checks++;
    if (cnt != 16) $display("FAIL clear_busy_cycles got %0d want 16", cnt);
    else n_pass++;
    read_word(4'd2, d, v);
    n_checks++;
    if (d !== 8'sd0 || v !== 1'b1) $display("FAIL cleared_addr2 got %0d valid=%b want 0 1", d, v);
    else n_pass++;
    read_word(4'd4, d, v);
    n_checks++;
    if (d !== 8'sd0) $display("FAIL cleared_addr4 got %0d want 0", d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #2;
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || sat_event !== 1'b0)
      $display("FAIL mid_reset busy=%b rd_valid=%b sat=%b want 1 0 0", busy, rd_valid, sat_event);
    else n_pass++;
    tick();
    reset   = 1'b0;
    rd_en   = 1'b1;
    rd_addr = 4'd1;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
      n_checks++;
      if (rd_valid !== 1'b0 || sat_event !== 1'b0)
        $display("FAIL restart_quiet rd_valid=%b sat=%b want 0 0", rd_valid, sat_event);
      else n_pass++;
    end
    rd_en = 1'b0;
    n_checks++;
    if (cnt != 16) $display("FAIL restart_busy_cycles got %0d want 16", cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_accum_forward();
    test_saturation();
    test_clear_during_busy();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
